// File: rtl/insts_queue_pkg.sv
// Shared instruction-queue types, widths and fetch-geometry macros.
// Purpose: supplies the fetch-packet geometry used by insts_queue and its compactor.
// Also provides a helper that computes a slot's PC and one that isolates the lowest set mask bit.
// Macros (overridable before this file): NUM_INSTS_FETCH_PER_CYCLE, SINGLE_INST_LEN_IN_BITS,
// SINGLE_INST_LEN_IN_BYTES, INSTS_FETCH_WIDTH_IN_BITS, CPU_WORD_LEN_IN_BITS, INSTS_QUEUE_DEPTH.

`ifndef NUM_INSTS_FETCH_PER_CYCLE
`define NUM_INSTS_FETCH_PER_CYCLE 4
`endif
`ifndef SINGLE_INST_LEN_IN_BITS
`define SINGLE_INST_LEN_IN_BITS 32
`endif
`ifndef SINGLE_INST_LEN_IN_BYTES
`define SINGLE_INST_LEN_IN_BYTES 4
`endif
`ifndef INSTS_FETCH_WIDTH_IN_BITS
`define INSTS_FETCH_WIDTH_IN_BITS (`NUM_INSTS_FETCH_PER_CYCLE * `SINGLE_INST_LEN_IN_BITS)
`endif
`ifndef CPU_WORD_LEN_IN_BITS
`define CPU_WORD_LEN_IN_BITS 32
`endif
`ifndef INSTS_QUEUE_DEPTH
`define INSTS_QUEUE_DEPTH 16
`endif

package insts_queue_pkg;

    localparam int NUM_FETCH  = `NUM_INSTS_FETCH_PER_CYCLE;
    localparam int INST_W     = `SINGLE_INST_LEN_IN_BITS;
    localparam int INST_BYTES = `SINGLE_INST_LEN_IN_BYTES;
    localparam int PKT_W      = `INSTS_FETCH_WIDTH_IN_BITS;
    localparam int WORD_W     = `CPU_WORD_LEN_IN_BITS;
    localparam int SLOT_OFF_W = $clog2(NUM_FETCH + 1);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [WORD_W-1:0] pc;
    } queue_entry_t;

    // PC of a packet slot, wrapping at the word width.
    function automatic logic [WORD_W-1:0] slot_pc(
        input logic [WORD_W-1:0] base,
        input int                slot
    );
        return base + WORD_W'(slot * INST_BYTES);
    endfunction

    // One-hot of the lowest set bit (zero if none).
    function automatic logic [NUM_FETCH-1:0] lowest_one(
        input logic [NUM_FETCH-1:0] m
    );
        return m & (~m + NUM_FETCH'(1));
    endfunction

endpackage

// File: rtl/insts_packet_compactor.sv
// Combinational compactor for a fetch packet's slot-valid mask.
// Ports: mask (per-slot valid) -> offset (per-slot write offset, i.e. count of
// valid slots below it) and enq_n (total number of valid slots).

module insts_packet_compactor
    import insts_queue_pkg::*;
#(
    parameter int N     = NUM_FETCH,
    parameter int OFF_W = $clog2(N + 1)
) (
    input  logic [N-1:0]            mask,
    output logic [N-1:0][OFF_W-1:0] offset,
    output logic [OFF_W-1:0]        enq_n
);

    logic [OFF_W-1:0] acc;

    // Exclusive prefix sum: each slot lands right after the valid slots below it.
    always_comb begin
        acc    = '0;
        offset = '0;
        for (int i = 0; i < N; i++) begin
            offset[i] = acc;
            acc       = acc + OFF_W'(mask[i]);
        end
        enq_n = acc;
    end

endmodule

// File: rtl/insts_queue.sv
// Instruction queue between fetch and decode: compacts packets, in-order circular buffer.
// Ports: clk_in, reset_in (async, active high); packet_in/packet_slot_valid_in/
// packet_pc_in/packet_valid_in with queue_ready_out (fetch side); inst_out/
// inst_pc_out/inst_valid_out with inst_ack_in (decode side); flush_in empties the queue.
// Option: define INSTS_QUEUE_BYPASS_EN to forward the lowest valid slot of a
// packet straight to the outputs when the queue is empty (zero-cycle latency).

module insts_queue
    import insts_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = `INSTS_QUEUE_DEPTH,
    parameter int PTR_W       = $clog2(QUEUE_DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic [PKT_W-1:0]     packet_in,
    input  logic [NUM_FETCH-1:0] packet_slot_valid_in,
    input  logic [WORD_W-1:0]    packet_pc_in,
    input  logic                 packet_valid_in,
    output logic                 queue_ready_out,
    output logic [INST_W-1:0]    inst_out,
    output logic [WORD_W-1:0]    inst_pc_out,
    output logic                 inst_valid_out,
    input  logic                 inst_ack_in,
    input  logic                 flush_in
);

    localparam int CNT_W = PTR_W + 1;

    queue_entry_t mem [QUEUE_DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic                                  stored_valid;
    logic                                  enq_fire;
    logic                                  deq_fire;
    logic [NUM_FETCH-1:0]                  wr_mask;
    logic [NUM_FETCH-1:0][SLOT_OFF_W-1:0]  offset;
    logic [SLOT_OFF_W-1:0]                 enq_n;
    logic [SLOT_OFF_W-1:0]                 enq_cnt;
    queue_entry_t                          slot_entry [NUM_FETCH];
    queue_entry_t                          head;

    assign stored_valid    = (count != '0);
    assign queue_ready_out = ~reset_in
                           & (count <= CNT_W'(QUEUE_DEPTH - NUM_FETCH));
    assign enq_fire        = packet_valid_in & queue_ready_out & ~flush_in;
    assign deq_fire        = stored_valid & inst_ack_in & ~flush_in;
    assign enq_cnt         = enq_fire ? enq_n : '0;
    assign head            = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < NUM_FETCH; i++) begin
            slot_entry[i].inst = packet_in[i*INST_W +: INST_W];
            slot_entry[i].pc   = slot_pc(packet_pc_in, i);
        end
    end

`ifdef INSTS_QUEUE_BYPASS_EN
    logic                 bypass_valid;
    logic                 bypass_taken;
    logic [NUM_FETCH-1:0] bypass_onehot;
    queue_entry_t         bypass_entry;

    // enq_fire already excludes flush, so flush suppresses the bypass too.
    assign bypass_valid  = enq_fire & ~stored_valid & (|packet_slot_valid_in);
    assign bypass_onehot = lowest_one(packet_slot_valid_in);
    assign bypass_taken  = bypass_valid & inst_ack_in;
    // A forwarded-and-acked slot is consumed and must not also be stored.
    assign wr_mask       = bypass_taken
                         ? (packet_slot_valid_in & ~bypass_onehot)
                         : packet_slot_valid_in;

    always_comb begin
        bypass_entry = '0;
        for (int i = 0; i < NUM_FETCH; i++) begin
            if (bypass_onehot[i]) begin
                bypass_entry = slot_entry[i];
            end
        end
    end
`else
    assign wr_mask = packet_slot_valid_in;
`endif

    insts_packet_compactor #(
        .N     (NUM_FETCH),
        .OFF_W (SLOT_OFF_W)
    ) u_compactor (
        .mask   (wr_mask),
        .offset (offset),
        .enq_n  (enq_n)
    );

    always_comb begin
        inst_valid_out = stored_valid;
        inst_out       = stored_valid ? head.inst : '0;
        inst_pc_out    = stored_valid ? head.pc   : '0;
`ifdef INSTS_QUEUE_BYPASS_EN
        if (bypass_valid) begin
            inst_valid_out = 1'b1;
            inst_out       = bypass_entry.inst;
            inst_pc_out    = bypass_entry.pc;
        end
`endif
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                for (int i = 0; i < NUM_FETCH; i++) begin
                    if (wr_mask[i]) begin
                        mem[wr_ptr + PTR_W'(offset[i])] <= slot_entry[i];
                    end
                end
                wr_ptr <= wr_ptr + PTR_W'(enq_n);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(enq_cnt) - CNT_W'(deq_fire);
        end
    end

endmodule

// File: tb/tb_insts_queue.sv
// Directed bench for insts_queue: vector table plus hand-written corner sequences.
// Expected PCs/instructions are computed here from the stimulus.

module tb_insts_queue;
    import insts_queue_pkg::*;

`ifdef INSTS_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [PKT_W-1:0]     packet;
    logic [NUM_FETCH-1:0] mask;
    logic [WORD_W-1:0]    ppc;
    logic                 pvalid;
    logic                 ready;
    logic [INST_W-1:0]    inst;
    logic [WORD_W-1:0]    ipc;
    logic                 ivalid;
    logic                 ack;
    logic                 flush;

    int npass  = 0;
    int ntotal = 0;

    insts_queue dut (
        .clk_in               (clk),
        .reset_in             (rst),
        .packet_in            (packet),
        .packet_slot_valid_in (mask),
        .packet_pc_in         (ppc),
        .packet_valid_in      (pvalid),
        .queue_ready_out      (ready),
        .inst_out             (inst),
        .inst_pc_out          (ipc),
        .inst_valid_out       (ivalid),
        .inst_ack_in          (ack),
        .flush_in             (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 pv;
        logic [NUM_FETCH-1:0] m;
        logic [WORD_W-1:0]    pc;
        logic                 a;
        logic                 byp;
        logic [WORD_W-1:0]    byp_pc;
        logic                 ev;
        logic [WORD_W-1:0]    epc;
        logic                 erdy;
        int                   ecnt;
    } vec_t;

    vec_t vt [15];

    function automatic logic [INST_W-1:0] mk_inst(input logic [WORD_W-1:0] p);
        return INST_W'({p[15:0] ^ 16'hC3A5, p[15:0]});
    endfunction

    function automatic logic [PKT_W-1:0] build_packet(input logic [WORD_W-1:0] b);
        logic [PKT_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_FETCH; i++)
            r[i*INST_W +: INST_W] = mk_inst(b + WORD_W'(i * INST_BYTES));
        return r;
    endfunction

    task automatic drive(input logic pv, input logic [NUM_FETCH-1:0] m,
                         input logic [WORD_W-1:0] p, input logic a,
                         input logic f);
        pvalid = pv;
        mask   = m;
        ppc    = p;
        packet = build_packet(p);
        ack    = a;
        flush  = f;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_head(input string name, input logic ev,
                            input logic [WORD_W-1:0] epc);
        chk({name, ".valid"}, 64'(ivalid), 64'(ev));
        chk({name, ".pc"}, 64'(ipc), ev ? 64'(epc) : 64'd0);
        chk({name, ".inst"}, 64'(inst), ev ? 64'(mk_inst(epc)) : 64'd0);
    endtask

    task automatic chk_count(input string name, input int c);
        chk({name, ".count"}, 64'(dut.count), 64'(c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          pv  m      pc          a  byp byp_pc      ev epc         rdy cnt
        vt[0]  = '{1, 4'hF, 32'h1000, 0, 1, 32'h1000, 0, 32'h0,    1, 0};
        vt[1]  = '{0, 4'h0, 32'h0,    1, 0, 32'h0,    1, 32'h1000, 1, 4};
        vt[2]  = '{0, 4'h0, 32'h0,    1, 0, 32'h0,    1, 32'h1004, 1, 3};
        vt[3]  = '{0, 4'h0, 32'h0,    1, 0, 32'h0,    1, 32'h1008, 1, 2};
        vt[4]  = '{0, 4'h0, 32'h0,    1, 0, 32'h0,    1, 32'h100C, 1, 1};
        vt[5]  = '{0, 4'h0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    1, 0};
        vt[6]  = '{1, 4'hA, 32'h2000, 0, 1, 32'h2004, 0, 32'h0,    1, 0};
        vt[7]  = '{0, 4'h0, 32'h0,    0, 0, 32'h0,    1, 32'h2004, 1, 2};
        vt[8]  = '{0, 4'h0, 32'h0,    1, 0, 32'h0,    1, 32'h2004, 1, 2};
        vt[9]  = '{0, 4'h0, 32'h0,    1, 0, 32'h0,    1, 32'h200C, 1, 1};
        vt[10] = '{0, 4'h0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    1, 0};
        vt[11] = '{1, 4'h0, 32'h2100, 0, 0, 32'h0,    0, 32'h0,    1, 0};
        vt[12] = '{0, 4'h0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    1, 0};
        vt[13] = '{0, 4'h0, 32'h0,    1, 0, 32'h0,    0, 32'h0,    1, 0};
        vt[14] = '{0, 4'h0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    1, 0};

        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("reset.ready", 64'(ready), 64'd0);
        chk_head("reset", 1'b0, '0);
        chk_count("reset", 0);
        #2 rst = 1'b0;
        #1 chk("post_reset.ready", 64'(ready), 64'd1);
        tick();

        // table-driven vectors: checks sample state before the applied edge
        for (int k = 0; k < 15; k++) begin
            logic          ev;
            logic [WORD_W-1:0] epc;
            drive(vt[k].pv, vt[k].m, vt[k].pc, vt[k].a, 1'b0);
            ev  = vt[k].ev;
            epc = vt[k].epc;
            if (BYP && vt[k].byp) begin
                ev  = 1'b1;
                epc = vt[k].byp_pc;
            end
            #1;
            chk_head($sformatf("vec%0d", k), ev, epc);
            chk($sformatf("vec%0d.ready", k), 64'(ready), 64'(vt[k].erdy));
            chk_count($sformatf("vec%0d", k), vt[k].ecnt);
            tick();
        end

        // full queue and hold-off
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'hF, 32'h4000 + 32'(16 * k), 1'b0, 1'b0);
            tick();
        end
        idle();
        #1;
        chk_count("full", 16);
        chk("full.ready", 64'(ready), 64'd0);
        chk_head("full", 1'b1, 32'h4000);
        drive(1'b1, 4'hF, 32'h5000, 1'b0, 1'b0);
        tick();
        idle();
        #1 chk_count("held_off", 16);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        chk_count("one_ack", 15);
        chk("one_ack.ready", 64'(ready), 64'd0);
        chk_head("one_ack", 1'b1, 32'h4004);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            tick();
        end
        idle();
        #1;
        chk_count("four_ack", 12);
        chk("four_ack.ready", 64'(ready), 64'd1);
        for (int j = 0; j < 12; j++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            #1 chk_head($sformatf("drain%0d", j), 1'b1, 32'h4010 + 32'(4 * j));
            tick();
        end
        idle();
        #1 chk_head("drained", 1'b0, '0);

        // wrap: write 12, read 12, write 8
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        idle();
        #1 chk("flush.wr_ptr", 64'(dut.wr_ptr), 64'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'hF, 32'h6000 + 32'(16 * k), 1'b0, 1'b0);
            tick();
        end
        for (int j = 0; j < 12; j++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            #1 chk_head($sformatf("wr12_%0d", j), 1'b1, 32'h6000 + 32'(4 * j));
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 4'hF, 32'h7000 + 32'(16 * k), 1'b0, 1'b0);
            tick();
        end
        idle();
        #1;
        chk("wrap.wr_ptr", 64'(dut.wr_ptr), 64'd4);
        chk_count("wrap", 8);
        for (int j = 0; j < 8; j++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            #1 chk_head($sformatf("wrap%0d", j), 1'b1, 32'h7000 + 32'(4 * j));
            tick();
        end

        // flush beats same-cycle enqueue and dequeue
        drive(1'b1, 4'hF, 32'hA000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'h3, 32'hA010, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        chk_count("pre_flush", 6);
        chk_head("pre_flush", 1'b1, 32'hA000);
        drive(1'b1, 4'hF, 32'h8000, 1'b1, 1'b1);
        tick();
        idle();
        #1;
        chk_count("flush", 0);
        chk_head("flush", 1'b0, '0);
        chk("flush.rd_ptr", 64'(dut.rd_ptr), 64'd0);
        tick();
        chk_count("flush_after", 0);

`ifdef INSTS_QUEUE_BYPASS_EN
        drive(1'b1, 4'h1, 32'h3000, 1'b1, 1'b0);
        #1 chk_head("bypass", 1'b1, 32'h3000);
        tick();
        idle();
        #1;
        chk_count("bypass", 0);
        chk_head("bypass_after", 1'b0, '0);
        drive(1'b1, 4'h1, 32'h3100, 1'b1, 1'b1);
        #1 chk_head("bypass_flush", 1'b0, '0);
        tick();
        idle();
`endif

        // asynchronous reset in the middle of operation
        drive(1'b1, 4'hF, 32'hB000, 1'b0, 1'b0);
        tick();
        idle();
        #2 rst = 1'b1;
        #1;
        chk_count("async_rst", 0);
        chk("async_rst.ready", 64'(ready), 64'd0);
        chk_head("async_rst", 1'b0, '0);
        #2 rst = 1'b0;
        tick();
        chk_count("after_rst", 0);
        chk("after_rst.ready", 64'(ready), 64'd1);
        chk_head("after_rst", 1'b0, '0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
